pipe_ctrl: RTL

Parametrised pipeline sequencer for the RV32IC core. It holds per-stage instruction, PC and valid state, and builds the backward stall chain from per-stage stalled requests. It inserts NOP bubbles and flushes younger stages on a taken jump/branch. It replaces the hand-written stage shifting in the core top, generalises it to any depth, and adds valid tracking, flush and retire reporting.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_stage_reg.sv | 41 ++++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: per-stage payload and the bubble encoding.
package pipe_pkg;

  localparam int unsigned INSTR_W = 30;
  localparam int unsigned PC_W    = 32;

  // instr[31:2] of addi x0,x0,0
  localparam logic [INSTR_W-1:0] NOP = 30'h4;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: holds, loads the upstream payload, or loads a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = NOP
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t q_q;
  stage_t q_d;

  // A bubble keeps the old PC so the stage still carries a meaningful address.
  always_comb begin
    q_d = q_q;
    if (load) begin
      if (bubble) begin
        q_d.valid = 1'b0;
        q_d.instr = BUBBLE_INSTR;
      end else begin
        q_d = d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '{valid: 1'b0, instr: BUBBLE_INSTR, pc: '0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Parametrised pipeline sequencer: stage state, backward stall chain, flush bubbles, retire.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned JUMP_STAGE = 2,
  parameter logic [29:0] NOP        = 30'h4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  input  logic [29:0]            fetch_instr,
  input  logic [XLEN-1:0]        fetch_pc,
  output logic                   fetch_ready,
  input  logic [STAGES-1:0]      stalled,
  input  logic                   flush,
  output logic                   flush_ack,
  output logic [STAGES-1:0]      stall,
  output logic [STAGES-1:0]      stage_valid,
  output logic [STAGES*30-1:0]   stage_instr,
  output logic [STAGES*XLEN-1:0] stage_pc,
  output logic                   retire_valid,
  output logic [XLEN-1:0]        retire_pc,
  output logic [31:0]            perf_retired,
  output logic [31:0]            perf_stalls
);

  import pipe_pkg::*;

  stage_t stage_q [STAGES];
  stage_t fetch_d;

  // A stall anywhere downstream freezes every older-to-younger stage above it.
  always_comb begin
    stall = '0;
    stall[STAGES-1] = stalled[STAGES-1];
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      stall[k] = stalled[k] | stall[k+1];
    end
  end

  assign fetch_ready = ~stall[0];
  assign flush_ack   = flush & ~stall[JUMP_STAGE];

  always_comb begin
    fetch_d.valid = fetch_valid;
    fetch_d.instr = fetch_valid ? fetch_instr : NOP;
    fetch_d.pc    = PC_W'(fetch_pc);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic   kill_c;
    logic   load_c;
    logic   bubble_c;
    stage_t d_c;

    // Stages younger than the resolving jump are squashed even if they asked to stall.
    if (k < JUMP_STAGE) begin : g_kill
      assign kill_c = flush_ack;
    end else begin : g_keep
      assign kill_c = 1'b0;
    end

    assign load_c = ~stall[k] | kill_c;

    if (k == 0) begin : g_head
      assign bubble_c = kill_c;
      assign d_c      = fetch_d;
    end else begin : g_body
      assign bubble_c = kill_c | stall[k-1];
      assign d_c      = stage_q[k-1];
    end

    pipe_stage_reg #(
      .BUBBLE_INSTR(NOP)
    ) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load_c),
      .bubble (bubble_c),
      .d      (d_c),
      .q      (stage_q[k])
    );

    assign stage_valid[k]             = stage_q[k].valid;
    assign stage_instr[30*k +: 30]    = stage_q[k].instr;
    assign stage_pc[XLEN*k +: XLEN]   = XLEN'(stage_q[k].pc);
  end

  assign retire_valid = stage_q[STAGES-1].valid & ~stall[STAGES-1];
  assign retire_pc    = XLEN'(stage_q[STAGES-1].pc);

`ifdef PIPE_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  logic [31:0] stalls_q;
  logic [31:0] stalls_d;

  always_comb begin
    retired_d = retired_q + 32'(retire_valid);
    stalls_d  = stalls_q + 32'(stall[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      retired_q <= retired_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_retired = '0;
  assign perf_stalls  = '0;
`endif

endmodule
